pipe_axil_arbiter: RTL and testbench
====================================

# pipe_axil_arbiter

Two-master to one-slave AXI-Lite arbiter between the instruction fetch unit (read-only master) and the load/store unit (read/write master) and the shared memory/peripheral slave. One transaction is outstanding at a time. Grant is held from address phase until response handshake. Grant is decided in an idle cycle and encoded in a small state machine.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all AR/AW channels
- DATA_WIDTH, 32, data width of R/W channels; WSTRB width is DATA_WIDTH/8

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ifu_araddr_i  in  ADDR_WIDTH  IFU read address
- ifu_arvalid_i  in  1  IFU read request
- ifu_arready_o  out  1  AR accepted
- ifu_rvalid_o  out  1  read data valid
- ifu_rdata_o  out  DATA_WIDTH  read data
- ifu_rready_i  in  1  IFU accepts data
- lsu_araddr_i / lsu_arvalid_i / lsu_arready_o  in/in/out  ADDR_WIDTH/1/1  LSU read address channel
- lsu_rvalid_o / lsu_rdata_o / lsu_rresp_o / lsu_rready_i  out/out/out/in  1/DATA_WIDTH/2/1  LSU read data channel
- lsu_awaddr_i / lsu_awvalid_i / lsu_awready_o  in/in/out  ADDR_WIDTH/1/1  LSU write address channel
- lsu_wdata_i / lsu_wstrb_i / lsu_wvalid_i / lsu_wready_o  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  LSU write data channel
- lsu_bvalid_o / lsu_bresp_o / lsu_bready_i  out/out/in  1/2/1  LSU write response
- m_ar*, m_r*, m_aw*, m_w*, m_b*  out/in per AXI-Lite  same widths  slave-side channels (araddr, arvalid, arready, rvalid, rdata, rresp, rready, awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bvalid, bresp, bready)

## Operation
- States: IDLE, IFU_RD, LSU_RD, LSU_WR.
- In IDLE, all slave-side valids are 0 and all master-side readys/valids are 0.
- IDLE transitions at the next edge according to fixed priority: LSU_WR (lsu_awvalid_i|lsu_wvalid_i), then LSU_RD (lsu_arvalid_i), then IFU_RD (ifu_arvalid_i). With no request, stay in IDLE.
- IFU_RD/LSU_RD:
  - Granted master's AR is forwarded to m_ar* until the AR handshake. A registered ar_done flag then forces m_arvalid=0.
  - m_r* is forwarded to the granted master: rvalid, rdata, rresp; rready comes back from the master.
  - On R handshake: transition to IDLE and clear ar_done.
- LSU_WR:
  - AW and W are forwarded independently. aw_done and w_done registers mask each channel after its handshake.
  - B is forwarded.
  - On B handshake: transition to IDLE and clear both flags.
- A non-granted master sees ready=0 and valid=0 on all of its channels. Its requests stay pending; masters must hold valid/address stable (AXI rule).
- R/B arriving before the AR/AW/W handshake completes is not legal slave behaviour; the block does not check for it.
- Reset mid-transaction: state goes to IDLE and the transaction is abandoned. The slave must be reset by the same rst_i.

## Timing
- Reset values: state IDLE, ar_done/aw_done/w_done 0, all *valid_o/*ready_o/m_*valid/m_*ready 0. Data/addr outputs are muxed and don't-care while the matching valid is low.
- Grant latency: a request that is valid in IDLE at edge N appears on m_*valid in cycle N+1.
- The AR/AW/W/R/B paths are combinational pass-throughs while granted, with zero added latency.
- Each transaction costs at least 1 IDLE cycle after its response handshake.
- Back-to-back requests from the same master each re-arbitrate.

## Configuration
- PIPE_ARB_RR_EN defined: round-robin between IFU and LSU. A last_grant_lsu register is updated on every grant.
  - When both IFU and LSU request in IDLE, the master not granted last wins.
  - LSU write still beats LSU read.
- Undefined: fixed priority LSU_WR > LSU_RD > IFU_RD. An LSU streaming requests can starve the IFU indefinitely.

## Test plan
- IFU read alone:
  - Stimulus: ifu_araddr_i=0x80000000, slave returns rdata=0x00000413 after 2 cycles.
  - Response: m_arvalid rises 1 cycle after the request, ifu_rvalid_o=1 with 0x00000413, then back to IDLE.
- Simultaneous IFU read and LSU read in IDLE, fixed priority:
  - Response: LSU completes first (lsu_rdata_o=0xDEADBEEF), then IFU is granted in the next IDLE cycle.
  - Response: ifu_arready_o stays 0 throughout the LSU transaction.
- LSU write with AW handshake 2 cycles before W:
  - Stimulus: slave bresp=2'b00.
  - Response: m_awvalid drops after the AW handshake, W completes, lsu_bvalid_o=1, and 1 IDLE cycle follows.
- Stalled consumer:
  - Stimulus: ifu_rready_i=0 for 3 cycles while rvalid is high.
  - Response: m_rready=0, state stays IFU_RD, and the data is held until rready rises.
- Reset asserted in LSU_RD after the AR handshake:
  - Response: all valids/readys are 0 immediately and the state is IDLE.
  - Response: after release, a new IFU request is granted normally.
- With PIPE_ARB_RR_EN, IFU and LSU requesting continuously:
  - Response: grants alternate LSU, IFU, LSU, IFU.

Source files
------------

// File: rtl/pipe_axil_arbiter_if.sv
// AXI-Lite link carrying AR/R/AW/W/B between one master and one slave; the
// arbiter uses one instance each for the IFU, the LSU and the shared slave.
interface pipe_axil_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic                    bvalid;
  logic [1:0]              bresp;
  logic                    bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/pipe_axil_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-Lite arbiter, one
// transaction in flight. Define PIPE_ARB_RR_EN for IFU/LSU round-robin grants.
module pipe_axil_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pipe_axil_arbiter_if.slave  ifu,
  pipe_axil_arbiter_if.slave  lsu,
  pipe_axil_arbiter_if.master m
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic ar_done;
  logic aw_done;
  logic w_done;

  logic ar_hs;
  logic aw_hs;
  logic w_hs;
  logic r_hs;
  logic b_hs;

  logic lsu_wr_req;
  logic lsu_rd_req;
  logic ifu_rd_req;
  logic lsu_wins;

  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [DATA_WIDTH-1:0] r_data;

  // The IFU never writes; its write-side inputs are intentionally ignored.
  logic ifu_unused;
  assign ifu_unused = ^{ifu.awaddr, ifu.awvalid, ifu.wdata, ifu.wstrb,
                        ifu.wvalid, ifu.bready};

  assign lsu_wr_req = lsu.awvalid | lsu.wvalid;
  assign lsu_rd_req = lsu.arvalid;
  assign ifu_rd_req = ifu.arvalid;

  assign ar_hs = m.arvalid & m.arready;
  assign aw_hs = m.awvalid & m.awready;
  assign w_hs  = m.wvalid  & m.wready;
  assign r_hs  = m.rvalid  & m.rready;
  assign b_hs  = m.bvalid  & m.bready;

  assign ar_addr = (state == IFU_RD) ? ifu.araddr : lsu.araddr;
  assign r_data  = m.rdata;

`ifdef PIPE_ARB_RR_EN
  // On contention the master that did not get the previous grant goes first.
  logic last_grant_lsu;

  assign lsu_wins = ~ifu_rd_req | ~last_grant_lsu;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_lsu <= 1'b0;
    end else if (state == IDLE && state_next != IDLE) begin
      last_grant_lsu <= (state_next != IFU_RD);
    end
  end
`else
  assign lsu_wins = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Per-channel done flags mask a request once its handshake has happened,
  // since masters may keep valid high until the response completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state_next == IDLE) begin
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (ar_hs) ar_done <= 1'b1;
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (lsu_wr_req && lsu_wins) begin
          state_next = LSU_WR;
        end else if (lsu_rd_req && lsu_wins) begin
          state_next = LSU_RD;
        end else if (ifu_rd_req) begin
          state_next = IFU_RD;
        end
      end
      IFU_RD, LSU_RD: begin
        if (r_hs) state_next = IDLE;
      end
      LSU_WR: begin
        if (b_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Data/address paths are always muxed; only valids and readys are gated by grant.
  always_comb begin
    ifu.arready = 1'b0;
    ifu.rvalid  = 1'b0;
    ifu.rdata   = r_data;
    ifu.rresp   = m.rresp;
    ifu.awready = 1'b0;
    ifu.wready  = 1'b0;
    ifu.bvalid  = 1'b0;
    ifu.bresp   = 2'b00;

    lsu.arready = 1'b0;
    lsu.rvalid  = 1'b0;
    lsu.rdata   = r_data;
    lsu.rresp   = m.rresp;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bvalid  = 1'b0;
    lsu.bresp   = m.bresp;

    m.araddr  = ar_addr;
    m.arvalid = 1'b0;
    m.rready  = 1'b0;
    m.awaddr  = lsu.awaddr;
    m.awvalid = 1'b0;
    m.wdata   = lsu.wdata;
    m.wstrb   = lsu.wstrb;
    m.wvalid  = 1'b0;
    m.bready  = 1'b0;

    unique case (state)
      IFU_RD: begin
        m.arvalid   = ifu.arvalid & ~ar_done;
        ifu.arready = m.arready & ~ar_done;
        ifu.rvalid  = m.rvalid;
        m.rready    = ifu.rready;
      end
      LSU_RD: begin
        m.arvalid   = lsu.arvalid & ~ar_done;
        lsu.arready = m.arready & ~ar_done;
        lsu.rvalid  = m.rvalid;
        m.rready    = lsu.rready;
      end
      LSU_WR: begin
        m.awvalid   = lsu.awvalid & ~aw_done;
        lsu.awready = m.awready & ~aw_done;
        m.wvalid    = lsu.wvalid & ~w_done;
        lsu.wready  = m.wready & ~w_done;
        lsu.bvalid  = m.bvalid;
        m.bready    = lsu.bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pipe_axil_arbiter.sv
// Directed bench for pipe_axil_arbiter: a grant/ownership model predicts every
// master- and slave-side valid/ready each cycle, plus literal spot checks.
module tb_pipe_axil_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  localparam int NONE  = 0;
  localparam int IFU   = 1;
  localparam int LSURD = 2;
  localparam int LSUWR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_axil_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifu_bus ();
  pipe_axil_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) lsu_bus ();
  pipe_axil_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

  pipe_axil_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ifu   (ifu_bus),
    .lsu   (lsu_bus),
    .m     (mem_bus)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: who owns the slave, and which request channels already handshook.
  int owner = NONE;
  bit ar_seen, aw_seen, w_seen;
  bit rr_last_lsu;
  int grant_log[$];

  function automatic int pick_grant();
    bit lsu_write = lsu_bus.awvalid || lsu_bus.wvalid;
    bit lsu_any   = lsu_write || lsu_bus.arvalid;
    int lsu_kind  = lsu_write ? LSUWR : LSURD;
    if (!lsu_any) return ifu_bus.arvalid ? IFU : NONE;
    if (!ifu_bus.arvalid) return lsu_kind;
`ifdef PIPE_ARB_RR_EN
    return rr_last_lsu ? IFU : lsu_kind;
`else
    return lsu_kind;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= NONE;
      ar_seen     <= 1'b0;
      aw_seen     <= 1'b0;
      w_seen      <= 1'b0;
      rr_last_lsu <= 1'b0;
    end else if (owner == NONE) begin
      owner <= pick_grant();
      if (pick_grant() != NONE) begin
        grant_log.push_back(pick_grant());
        rr_last_lsu <= (pick_grant() != IFU);
      end
    end else if (owner == IFU || owner == LSURD) begin
      if (!ar_seen && mem_bus.arready &&
          (owner == IFU ? ifu_bus.arvalid : lsu_bus.arvalid)) ar_seen <= 1'b1;
      if (mem_bus.rvalid && (owner == IFU ? ifu_bus.rready : lsu_bus.rready)) begin
        owner   <= NONE;
        ar_seen <= 1'b0;
      end
    end else begin
      if (!aw_seen && lsu_bus.awvalid && mem_bus.awready) aw_seen <= 1'b1;
      if (!w_seen && lsu_bus.wvalid && mem_bus.wready) w_seen <= 1'b1;
      if (mem_bus.bvalid && lsu_bus.bready) begin
        owner   <= NONE;
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
      end
    end
  end

  function automatic logic [14:0] actual_ctrl();
    return {ifu_bus.arready, ifu_bus.rvalid, ifu_bus.awready, ifu_bus.wready, ifu_bus.bvalid,
            lsu_bus.arready, lsu_bus.rvalid, lsu_bus.awready, lsu_bus.wready, lsu_bus.bvalid,
            mem_bus.arvalid, mem_bus.rready, mem_bus.awvalid, mem_bus.wvalid, mem_bus.bready};
  endfunction

  function automatic logic [14:0] expected_ctrl();
    logic [14:0] e = '0;
    bit i_rd = (owner == IFU);
    bit l_rd = (owner == LSURD);
    bit wr   = (owner == LSUWR);
    e[14] = i_rd && !ar_seen && mem_bus.arready;
    e[13] = i_rd && mem_bus.rvalid;
    e[9]  = l_rd && !ar_seen && mem_bus.arready;
    e[8]  = l_rd && mem_bus.rvalid;
    e[7]  = wr && !aw_seen && mem_bus.awready;
    e[6]  = wr && !w_seen && mem_bus.wready;
    e[5]  = wr && mem_bus.bvalid;
    e[4]  = !ar_seen && ((i_rd && ifu_bus.arvalid) || (l_rd && lsu_bus.arvalid));
    e[3]  = (i_rd && ifu_bus.rready) || (l_rd && lsu_bus.rready);
    e[2]  = wr && !aw_seen && lsu_bus.awvalid;
    e[1]  = wr && !w_seen && lsu_bus.wvalid;
    e[0]  = wr && lsu_bus.bready;
    return e;
  endfunction

  always @(negedge clk) begin
    logic [14:0] e;
    e = expected_ctrl();
    check_output("cyc_ctrl", {17'd0, actual_ctrl()}, {17'd0, e});
    if (e[4])
      check_output("cyc_m_araddr", mem_bus.araddr,
                   owner == IFU ? ifu_bus.araddr : lsu_bus.araddr);
    if (e[13]) check_output("cyc_ifu_rdata", ifu_bus.rdata, mem_bus.rdata);
    if (e[8]) begin
      check_output("cyc_lsu_rdata", lsu_bus.rdata, mem_bus.rdata);
      check_output("cyc_lsu_rresp", {30'd0, lsu_bus.rresp}, {30'd0, mem_bus.rresp});
    end
    if (e[2]) check_output("cyc_m_awaddr", mem_bus.awaddr, lsu_bus.awaddr);
    if (e[1]) begin
      check_output("cyc_m_wdata", mem_bus.wdata, lsu_bus.wdata);
      check_output("cyc_m_wstrb", {28'd0, mem_bus.wstrb}, {28'd0, lsu_bus.wstrb});
    end
    if (e[5]) check_output("cyc_lsu_bresp", {30'd0, lsu_bus.bresp}, {30'd0, mem_bus.bresp});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_addr [4];

    ifu_bus.araddr = '0; ifu_bus.arvalid = 1'b0; ifu_bus.rready = 1'b0;
    ifu_bus.awaddr = '0; ifu_bus.awvalid = 1'b0; ifu_bus.wdata = '0;
    ifu_bus.wstrb = '0; ifu_bus.wvalid = 1'b0; ifu_bus.bready = 1'b0;
    lsu_bus.araddr = '0; lsu_bus.arvalid = 1'b0; lsu_bus.rready = 1'b0;
    lsu_bus.awaddr = '0; lsu_bus.awvalid = 1'b0; lsu_bus.wdata = '0;
    lsu_bus.wstrb = '0; lsu_bus.wvalid = 1'b0; lsu_bus.bready = 1'b0;
    mem_bus.arready = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
    mem_bus.rresp = '0; mem_bus.awready = 1'b0; mem_bus.wready = 1'b0;
    mem_bus.bvalid = 1'b0; mem_bus.bresp = '0;

    rst = 1'b1;
    tick(2);
    check_output("reset_ctrl", {17'd0, actual_ctrl()}, 32'd0);
    rst = 1'b0;

    // IFU read alone
    ifu_bus.araddr = 32'h8000_0000; ifu_bus.arvalid = 1'b1; ifu_bus.rready = 1'b1;
    mem_bus.arready = 1'b1;
    #1;
    check_output("t1_idle_m_arvalid", {31'd0, mem_bus.arvalid}, 32'd0);
    tick(1);
    check_output("t1_m_arvalid", {31'd0, mem_bus.arvalid}, 32'd1);
    check_output("t1_m_araddr", mem_bus.araddr, 32'h8000_0000);
    tick(1);
    ifu_bus.arvalid = 1'b0; mem_bus.arready = 1'b0;
    tick(1);
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h0000_0413;
    #1;
    check_output("t1_ifu_rvalid", {31'd0, ifu_bus.rvalid}, 32'd1);
    check_output("t1_ifu_rdata", ifu_bus.rdata, 32'h0000_0413);
    tick(1);
    mem_bus.rvalid = 1'b0;
    #1;
    check_output("t1_after_ctrl", {17'd0, actual_ctrl()}, 32'd0);
    check_output("t1_model_owner", owner, NONE);

    // simultaneous IFU and LSU reads
    ifu_bus.araddr = 32'h8000_0004; ifu_bus.arvalid = 1'b1;
    lsu_bus.araddr = 32'h1000_0000; lsu_bus.arvalid = 1'b1; lsu_bus.rready = 1'b1;
    tick(1);
    check_output("t2_m_araddr_lsu", mem_bus.araddr, 32'h1000_0000);
    mem_bus.arready = 1'b1;
    #1;
    check_output("t2_lsu_arready", {31'd0, lsu_bus.arready}, 32'd1);
    check_output("t2_ifu_arready", {31'd0, ifu_bus.arready}, 32'd0);
    tick(1);
    lsu_bus.arvalid = 1'b0; mem_bus.arready = 1'b0;
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'hDEAD_BEEF; mem_bus.rresp = 2'b00;
    #1;
    check_output("t2_lsu_rdata", lsu_bus.rdata, 32'hDEAD_BEEF);
    check_output("t2_ifu_rvalid", {31'd0, ifu_bus.rvalid}, 32'd0);
    tick(1);
    mem_bus.rvalid = 1'b0;
    #1;
    check_output("t2_gap_m_arvalid", {31'd0, mem_bus.arvalid}, 32'd0);
    tick(1);
    check_output("t2_ifu_m_arvalid", {31'd0, mem_bus.arvalid}, 32'd1);
    check_output("t2_ifu_m_araddr", mem_bus.araddr, 32'h8000_0004);
    mem_bus.arready = 1'b1;
    tick(1);
    ifu_bus.arvalid = 1'b0; mem_bus.arready = 1'b0;
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h0000_0013;
    #1;
    check_output("t2_ifu_rdata", ifu_bus.rdata, 32'h0000_0013);
    tick(1);
    mem_bus.rvalid = 1'b0;
    check_output("t2_model_grant_a", grant_log[1], LSURD);
    check_output("t2_model_grant_b", grant_log[2], IFU);

    // LSU write, AW two cycles ahead of W
    lsu_bus.awaddr = 32'h0000_2000; lsu_bus.awvalid = 1'b1; lsu_bus.bready = 1'b1;
    mem_bus.awready = 1'b1; mem_bus.wready = 1'b1;
    tick(1);
    check_output("t3_m_awvalid", {31'd0, mem_bus.awvalid}, 32'd1);
    check_output("t3_m_awaddr", mem_bus.awaddr, 32'h0000_2000);
    check_output("t3_m_wvalid_early", {31'd0, mem_bus.wvalid}, 32'd0);
    tick(1);
    check_output("t3_m_awvalid_masked", {31'd0, mem_bus.awvalid}, 32'd0);
    check_output("t3_lsu_awready_masked", {31'd0, lsu_bus.awready}, 32'd0);
    tick(1);
    lsu_bus.awvalid = 1'b0;
    lsu_bus.wvalid = 1'b1; lsu_bus.wdata = 32'hCAFE_F00D; lsu_bus.wstrb = 4'hF;
    #1;
    check_output("t3_m_wvalid", {31'd0, mem_bus.wvalid}, 32'd1);
    check_output("t3_m_wdata", mem_bus.wdata, 32'hCAFE_F00D);
    tick(1);
    lsu_bus.wvalid = 1'b0;
    mem_bus.bvalid = 1'b1; mem_bus.bresp = 2'b00;
    #1;
    check_output("t3_lsu_bvalid", {31'd0, lsu_bus.bvalid}, 32'd1);
    check_output("t3_lsu_bresp", {30'd0, lsu_bus.bresp}, 32'd0);
    tick(1);
    mem_bus.bvalid = 1'b0; mem_bus.awready = 1'b0; mem_bus.wready = 1'b0;
    #1;
    check_output("t3_idle_ctrl", {17'd0, actual_ctrl()}, 32'd0);
    check_output("t3_model_grant", grant_log[3], LSUWR);

    // stalled IFU consumer
    ifu_bus.araddr = 32'h8000_0008; ifu_bus.arvalid = 1'b1; ifu_bus.rready = 1'b0;
    mem_bus.arready = 1'b1;
    tick(2);
    ifu_bus.arvalid = 1'b0; mem_bus.arready = 1'b0;
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h0010_0093;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output($sformatf("t4_m_rready_%0d", i), {31'd0, mem_bus.rready}, 32'd0);
      check_output($sformatf("t4_ifu_rvalid_%0d", i), {31'd0, ifu_bus.rvalid}, 32'd1);
      check_output($sformatf("t4_ifu_rdata_%0d", i), ifu_bus.rdata, 32'h0010_0093);
      tick(1);
    end
    ifu_bus.rready = 1'b1;
    #1;
    check_output("t4_m_rready", {31'd0, mem_bus.rready}, 32'd1);
    tick(1);
    mem_bus.rvalid = 1'b0;
    #1;
    check_output("t4_ifu_rvalid_done", {31'd0, ifu_bus.rvalid}, 32'd0);

    // reset in LSU_RD after the AR handshake
    lsu_bus.araddr = 32'h1000_0010; lsu_bus.arvalid = 1'b1; lsu_bus.rready = 1'b0;
    mem_bus.arready = 1'b1;
    tick(2);
    lsu_bus.arvalid = 1'b0; mem_bus.arready = 1'b0;
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h1234_5678;
    #1;
    check_output("t5_lsu_rvalid", {31'd0, lsu_bus.rvalid}, 32'd1);
    rst = 1'b1;
    #1;
    check_output("t5_rst_ctrl", {17'd0, actual_ctrl()}, 32'd0);
    check_output("t5_model_owner", owner, NONE);
    mem_bus.rvalid = 1'b0;
    tick(2);
    rst = 1'b0;
    ifu_bus.araddr = 32'h8000_0100; ifu_bus.arvalid = 1'b1; ifu_bus.rready = 1'b1;
    mem_bus.arready = 1'b1;
    tick(1);
    check_output("t5_ifu_m_arvalid", {31'd0, mem_bus.arvalid}, 32'd1);
    check_output("t5_ifu_m_araddr", mem_bus.araddr, 32'h8000_0100);
    tick(1);
    ifu_bus.arvalid = 1'b0; mem_bus.arready = 1'b0;
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h0000_0297;
    #1;
    check_output("t5_ifu_rvalid", {31'd0, ifu_bus.rvalid}, 32'd1);
    tick(1);
    mem_bus.rvalid = 1'b0;

    // IFU and LSU requesting continuously
`ifdef PIPE_ARB_RR_EN
    exp_addr[0] = 32'h1000_0040; exp_addr[1] = 32'h8000_0200;
    exp_addr[2] = 32'h1000_0040; exp_addr[3] = 32'h8000_0200;
`else
    exp_addr[0] = 32'h1000_0040; exp_addr[1] = 32'h1000_0040;
    exp_addr[2] = 32'h1000_0040; exp_addr[3] = 32'h1000_0040;
`endif
    ifu_bus.araddr = 32'h8000_0200; ifu_bus.arvalid = 1'b1;
    lsu_bus.araddr = 32'h1000_0040; lsu_bus.arvalid = 1'b1; lsu_bus.rready = 1'b1;
    mem_bus.arready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick(1);
      check_output($sformatf("t6_grant%0d_addr", t), mem_bus.araddr, exp_addr[t]);
      tick(1);
      mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'(t);
      tick(1);
      mem_bus.rvalid = 1'b0;
    end
    ifu_bus.arvalid = 1'b0; lsu_bus.arvalid = 1'b0; mem_bus.arready = 1'b0;
    tick(2);
    check_output("end_model_grant_count", grant_log.size(), 11);
    check_output("end_idle_ctrl", {17'd0, actual_ctrl()}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
